nibble_add_sequencer: RTL and testbench

Multi-cycle adder/subtractor controller that drives a single 4-bit ripple-carry adder slice over successive clock cycles to add or subtract wide operands one nibble at a time, least-significant nibble first. It carries the inter-nibble carry in a register, handles operand capture and the start/busy/done handshake, and produces carry-out and signed overflow. It sits between switch/register operand sources and LED or downstream result consumers wherever one narrow adder is time-shared instead of building a wide one.

---
 rtl/nibble_add_sequencer.sv | 96 +++++++++
 tb/tb_nibble_add_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: time-shares one 4-bit ripple-carry slice to add or subtract
// W-bit operands one nibble per cycle, least-significant nibble first.
module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg, b_reg;
    logic [3:0]    na, nb, s;
    logic [4:0]    c;
    logic          last;

    assign last = idx == IW'(NIBBLES - 1);
    assign na   = a_reg[4*idx +: 4];
    assign nb   = b_reg[4*idx +: 4];

    always_comb begin
        c[0] = carry;
        s    = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]   = na[i] ^ nb[i] ^ c[i];
            c[i+1] = (na[i] & nb[i]) | (c[i] & (na[i] ^ nb[i]));
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && start)
            state_n = RUN;
        else if (state == RUN && last)
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            busy <= state_n == RUN;
            done <= state_n == DONE;
            if (state == IDLE && start) begin
                a_reg <= a;
                b_reg <= sub ? ~b : b;
                carry <= sub | cin;
                sum   <= '0;
                cout  <= 1'b0;
                ovf   <= 1'b0;
                idx   <= '0;
            end else if (state == RUN) begin
                sum[4*idx +: 4] <= s;
                carry           <= c[4];
                idx             <= idx + 1'b1;
                // Overflow compares the carries into and out of the top bit of the last slice
                if (last) begin
                    cout <= c[4];
                    ovf  <= c[3] ^ c[4];
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer: directed vectors; the driver queues expected results and a
// done-triggered monitor pops and compares them.
module tb_nibble_add_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    nibble_add_sequencer #(.NIBBLES(4)) dut (
        .CLOCK_50(clk), .reset(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            logic [17:0] e;
            chk("busy_done_exclusive", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result_sum_cout_ovf", 32'({sum, cout, ovf}), 32'(e));
            end
        end
    end

    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts, input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts, input logic tc,
                      input logic [15:0] es, input logic ec, input logic eo);
        int n;
        exp_q.push_back({es, ec, eo});
        launch(ta, tb_v, ts, tc);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_latency_edges", 32'(n), 32'd4);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        #12;
        chk("reset_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // start pulses in RUN and DONE must be ignored; changed operand must not leak in
        exp_q.push_back({16'h3333, 1'b0, 1'b0});
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        a = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("partial_sum_two_nibbles", 32'(sum), 32'h0033);
        repeat (2) @(posedge clk);
        #1;
        chk("done_in_done_state", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("no_restart_from_done", 32'(busy), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("sum_held_after_done", 32'({sum, cout, ovf}), 32'({16'h3333, 2'b00}));

        // asynchronous reset mid-operation discards it
        launch(16'hABCD, 16'h1111, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("idle_after_reset", 32'({busy, done}), 32'd0);
        op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
